// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master: FSM encoding, SPI mode
// constants and the legal parameter ranges checked at elaboration.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DATA_W_MIN  = 4;
  localparam int DATA_W_MAX  = 32;
  localparam int CLK_DIV_MIN = 2;
  localparam int CLK_DIV_MAX = 255;
  localparam int NUM_CS_MIN  = 1;
  localparam int NUM_CS_MAX  = 8;

  // A transfer spans 2*DATA_W+2 half-periods; the counter must also hold the wrap value.
  function automatic int half_cnt_w(input int data_w);
    return $clog2(2 * data_w + 3);
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCK timing base: divides clk into half-periods and flags the cycle just
// before each leading or trailing SCK edge of the shift phase.
module spi_edge_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  localparam int HPW    = half_cnt_w(DATA_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  output logic           period_end,
  output logic           lead_edge,
  output logic           trail_edge,
  output logic [HPW-1:0] half_cnt
);

  localparam logic [7:0]     DIV_LAST     = 8'(CLK_DIV - 1);
  localparam logic [HPW-1:0] HP_SHIFT_END = HPW'(2 * DATA_W);

  logic [7:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      div_cnt  <= '0;
      half_cnt <= '0;
    end else if (period_end) begin
      div_cnt  <= '0;
      half_cnt <= half_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Half-period 0 is setup, 1..2*DATA_W is shift; ending an even one yields a leading edge.
  assign period_end = run && (div_cnt == DIV_LAST);
  assign lead_edge  = period_end && !half_cnt[0] && (half_cnt < HP_SHIFT_END);
  assign trail_edge = period_end &&  half_cnt[0] && (half_cnt < HP_SHIFT_END);

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: one word per request, all four SPI modes,
// selectable chip select with optional hold across consecutive words.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  localparam int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              hold_cs,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              new_data
);

  localparam int             HPW           = half_cnt_w(DATA_W);
  localparam logic [HPW-1:0] HP_SHIFT_END  = HPW'(2 * DATA_W);
  localparam logic [HPW-1:0] HP_LAST_TRAIL = HPW'(2 * DATA_W - 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("spi_master_cfg: DATA_W outside legal range");
  end
  if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
    $error("spi_master_cfg: CLK_DIV outside legal range");
  end
  if (NUM_CS < NUM_CS_MIN || NUM_CS > NUM_CS_MAX) begin : g_bad_num_cs
    $error("spi_master_cfg: NUM_CS outside legal range");
  end

  spi_state_e        state_q, state_d;
  logic              running, accept, finish, cs_valid;
  logic              period_end, lead_edge, trail_edge;
  logic [HPW-1:0]    half_cnt;
  logic              cpha_q, hold_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic              shift_out, sample_in;

  assign running  = (state_q != ST_IDLE);
  assign cs_valid = (32'(cs_sel) < NUM_CS);
  assign busy     = running || new_data;

  spi_edge_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_edge_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (running),
    .period_end (period_end),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .half_cnt   (half_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // new_data doubles as the completion cycle, so a request seen then is dropped.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !new_data && cs_valid) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (period_end) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (period_end && (half_cnt == HP_SHIFT_END)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (period_end) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With cpha=0 the MSB is presented early, so the final trailing edge must not advance mosi.
  assign shift_out = cpha_q ? lead_edge : (trail_edge && (half_cnt != HP_LAST_TRAIL));
  assign sample_in = cpha_q ? trail_edge : lead_edge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cpha_q   <= 1'b0;
      hold_q   <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      mosi     <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= '1;
      data_out <= '0;
      new_data <= 1'b0;
    end else begin
      new_data <= finish;
      if (accept) begin
        cpha_q <= cpha;
        hold_q <= hold_cs;
        sck    <= cpol;
        cs_n   <= ~(NUM_CS'(1) << cs_sel);
        rx_sh  <= '0;
        if (cpha) begin
          mosi  <= 1'b0;
          tx_sh <= data_in;
        end else begin
          mosi  <= data_in[DATA_W-1];
          tx_sh <= data_in << 1;
        end
      end else begin
        if (lead_edge || trail_edge) sck <= ~sck;
        if (shift_out) begin
          mosi  <= tx_sh[DATA_W-1];
          tx_sh <= tx_sh << 1;
        end
        if (sample_in) rx_sh <= {rx_sh[DATA_W-2:0], miso};
        if (finish) begin
          data_out <= rx_sh;
          mosi     <= 1'b0;
          if (!hold_q) cs_n <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: an 8-bit single-CS master with loopback
// or a mode-aware slave, plus a 16-bit four-CS master for held chip selects.
module tb_spi_master_cfg;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Eight-bit, single chip-select instance
  logic       startA = 1'b0, cpolA = 1'b0, cphaA = 1'b0, holdA = 1'b0;
  logic [0:0] csSelA = '0;
  logic [7:0] dataInA = '0;
  logic       misoA, mosiA, sckA, busyA, newDataA;
  logic [0:0] csNA;
  logic [7:0] dataOutA;

  // Sixteen-bit, four chip-select instance
  logic        startB = 1'b0, cpolB = 1'b0, cphaB = 1'b0, holdB = 1'b0;
  logic [1:0]  csSelB = '0;
  logic [15:0] dataInB = '0;
  logic        misoB, mosiB, sckB, busyB, newDataB;
  logic [3:0]  csNB;
  logic [15:0] dataOutB;

  // Slave model for instance A
  logic       useSlave = 1'b0, slCpol = 1'b0, slCpha = 1'b0;
  logic [7:0] slWord = '0;
  logic [7:0] slTx, slRx;
  logic       slMiso, slPrevSck;

  assign misoA = useSlave ? slMiso : mosiA;
  assign misoB = mosiB;

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .data_in(dataInA), .cpol(cpolA),
    .cpha(cphaA), .cs_sel(csSelA), .hold_cs(holdA), .miso(misoA), .mosi(mosiA),
    .sck(sckA), .cs_n(csNA), .data_out(dataOutA), .busy(busyA), .new_data(newDataA)
  );

  spi_master_cfg #(.DATA_W(16), .CLK_DIV(4), .NUM_CS(4)) dutB (
    .clk(clk), .rst(rst), .start(startB), .data_in(dataInB), .cpol(cpolB),
    .cpha(cphaB), .cs_sel(csSelB), .hold_cs(holdB), .miso(misoB), .mosi(mosiB),
    .sck(sckB), .cs_n(csNB), .data_out(dataOutB), .busy(busyB), .new_data(newDataB)
  );

  // Samples on its sample edge, shifts on the other; only the last 8 samples matter.
  always @(sckA or csNA or slWord) begin
    if (csNA[0]) begin
      slTx = slWord;
    end else if (sckA != slPrevSck) begin
      if ((sckA != slCpol) ^ slCpha) slRx = {slRx[6:0], mosiA};
      else begin
        slMiso = slTx[7];
        slTx   = {slTx[6:0], 1'b0};
      end
    end
    slPrevSck = sckA;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle T+1.
  task automatic applyStimulus(input logic [7:0] data, input logic pol, input logic pha,
                               input logic sel, input logic hold);
    dataInA = data; cpolA = pol; cphaA = pha; csSelA = sel; holdA = hold;
    startA  = 1'b1;
    @(negedge clk);
    startA  = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [15:0] data, input logic [1:0] sel, input logic hold);
    dataInB = data; cpolB = 1'b0; cphaB = 1'b0; csSelB = sel; holdB = hold;
    startB  = 1'b1;
    @(negedge clk);
    startB  = 1'b0;
  endtask

  // Observes cycles T+1..T+80 of an instance-A word; injAt>0 also pulses start at injAt and T+73.
  task automatic watchWordA(input int injAt, output int doneAt, output int pulses, output int rises,
                            output int csBad, output logic busy73, output logic busy74);
    logic prevSck;
    prevSck = sckA; doneAt = 0; pulses = 0; rises = 0; csBad = 0; busy73 = 1'b0; busy74 = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (newDataA) begin
        pulses++;
        if (doneAt == 0) doneAt = k;
      end
      if (!prevSck && sckA) rises++;
      prevSck = sckA;
      if (k <= 72 && csNA !== 1'b0) csBad++;
      if (k == 73 && csNA !== 1'b1) csBad++;
      if (k == 73) busy73 = busyA;
      if (k == 74) busy74 = busyA;
      startA = (injAt != 0) && (k == injAt || k == 73);
      if (startA) begin
        dataInA = 8'hFF; cpolA = 1'b1; cphaA = 1'b1;
      end
      @(negedge clk);
    end
    startA = 1'b0;
  endtask

  // Runs until instance B completes (bounded); returns at the falling edge after completion.
  task automatic watchWordB(output int doneAt, output logic [3:0] csAtDone,
                            output logic [15:0] dataAtDone, output int csBad);
    int k;
    doneAt = 0; csBad = 0; csAtDone = '0; dataAtDone = '0; k = 1;
    while (doneAt == 0 && k <= 200) begin
      if (newDataB) begin
        doneAt = k; csAtDone = csNB; dataAtDone = dataOutB;
      end else if (csNB !== 4'b1011) begin
        csBad++;
      end
      k++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] stopped by watchdog");
  end

  initial begin
    int doneAt, pulses, rises, csBad, extra;
    logic busy73, busy74;
    logic [3:0] csDone;
    logic [15:0] dataDone;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_new_data", newDataA, 0);
    checkOutput("rst_sck", sckA, 0);
    checkOutput("rst_mosi", mosiA, 0);
    checkOutput("rst_cs_n", csNA, 1);
    checkOutput("rst_data_out", dataOutA, 0);
    checkOutput("rst_cs_n_b", csNB, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy", busyA, 0);
    checkOutput("post_rst_sck", sckA, 0);

    $display("[TB] mode 0 loopback 0xA5");
    applyStimulus(8'hA5, MODE0[1], MODE0[0], 1'b0, 1'b0);
    checkOutput("m0_busy_t1", busyA, 1);
    checkOutput("m0_cs_t1", csNA, 0);
    checkOutput("m0_sck_t1", sckA, 0);
    checkOutput("m0_mosi_msb_t1", mosiA, 1);
    watchWordA(0, doneAt, pulses, rises, csBad, busy73, busy74);
    checkOutput("m0_done_cycle", doneAt, 73);
    checkOutput("m0_pulses", pulses, 1);
    checkOutput("m0_sck_rises", rises, 8);
    checkOutput("m0_cs_window", csBad, 0);
    checkOutput("m0_busy_t73", busy73, 1);
    checkOutput("m0_busy_t74", busy74, 0);
    checkOutput("m0_data_out", dataOutA, 8'hA5);
    checkOutput("m0_idle_mosi", mosiA, 0);
    checkOutput("m0_idle_sck", sckA, 0);

    $display("[TB] mode 3 slave returns 0x3C, master sends 0xC3");
    useSlave = 1'b1; slCpol = 1'b1; slCpha = 1'b1; slWord = 8'h3C;
    @(negedge clk);
    applyStimulus(8'hC3, MODE3[1], MODE3[0], 1'b0, 1'b0);
    checkOutput("m3_sck_t1", sckA, 1);
    checkOutput("m3_cs_t1", csNA, 0);
    watchWordA(0, doneAt, pulses, rises, csBad, busy73, busy74);
    checkOutput("m3_done_cycle", doneAt, 73);
    checkOutput("m3_sck_rises", rises, 8);
    checkOutput("m3_cs_window", csBad, 0);
    checkOutput("m3_data_out", dataOutA, 8'h3C);
    checkOutput("m3_slave_rx", slRx, 8'hC3);
    checkOutput("m3_idle_sck", sckA, 1);
    useSlave = 1'b0;

    $display("[TB] start during busy and in completion cycle");
    applyStimulus(8'h69, MODE0[1], MODE0[0], 1'b0, 1'b0);
    watchWordA(10, doneAt, pulses, rises, csBad, busy73, busy74);
    checkOutput("inj_done_cycle", doneAt, 73);
    checkOutput("inj_pulses", pulses, 1);
    checkOutput("inj_data_out", dataOutA, 8'h69);
    checkOutput("inj_busy_t74", busy74, 0);
    checkOutput("inj_idle_sck", sckA, 0);

    $display("[TB] out-of-range chip select");
    applyStimulus(8'h11, MODE0[1], MODE0[0], 1'b1, 1'b0);
    checkOutput("badcs_busy", busyA, 0);
    checkOutput("badcs_cs_n", csNA, 1);
    @(negedge clk);
    checkOutput("badcs_busy_later", busyA, 0);

    $display("[TB] reset in the middle of a transfer");
    applyStimulus(8'h77, MODE3[1], MODE3[0], 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    checkOutput("midrst_sck_before", sckA, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midrst_busy", busyA, 0);
    checkOutput("midrst_cs_n", csNA, 1);
    checkOutput("midrst_sck", sckA, 0);
    checkOutput("midrst_data_out", dataOutA, 0);
    checkOutput("midrst_new_data", newDataA, 0);
    @(negedge clk);
    checkOutput("midrst_first_sck", sckA, 0);
    checkOutput("midrst_first_new_data", newDataA, 0);
    extra = 0;
    for (int k = 0; k < 80; k++) begin
      if (newDataA || busyA) extra++;
      @(negedge clk);
    end
    checkOutput("midrst_quiet", extra, 0);
    applyStimulus(8'h5A, MODE0[1], MODE0[0], 1'b0, 1'b0);
    watchWordA(0, doneAt, pulses, rises, csBad, busy73, busy74);
    checkOutput("fresh_done_cycle", doneAt, 73);
    checkOutput("fresh_pulses", pulses, 1);
    checkOutput("fresh_data_out", dataOutA, 8'h5A);

    $display("[TB] 16-bit words with held chip select 2");
    applyStimulusB(16'h1234, 2'd2, 1'b1);
    checkOutput("b1_cs_t1", csNB, 4'b1011);
    watchWordB(doneAt, csDone, dataDone, csBad);
    checkOutput("b1_done_cycle", doneAt, 137);
    checkOutput("b1_data_out", dataDone, 16'h1234);
    checkOutput("b1_cs_at_done", csDone, 4'b1011);
    checkOutput("b1_cs_window", csBad, 0);
    checkOutput("b1_busy_after", busyB, 0);
    checkOutput("b1_cs_after", csNB, 4'b1011);
    applyStimulusB(16'hBEEF, 2'd2, 1'b0);
    checkOutput("b2_cs_t1", csNB, 4'b1011);
    watchWordB(doneAt, csDone, dataDone, csBad);
    checkOutput("b2_done_cycle", doneAt, 137);
    checkOutput("b2_data_out", dataDone, 16'hBEEF);
    checkOutput("b2_cs_at_done", csDone, 4'b1111);
    checkOutput("b2_cs_window", csBad, 0);
    checkOutput("b2_cs_after", csNB, 4'b1111);
    checkOutput("b2_busy_after", busyB, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
